// File: rtl/cp0_tlb_regfile_if.sv
// CP0 register file bus: mtc0/mfc0 access, commit events, TLB results and
// exported register values. The master drives the pipeline side.
interface cp0_tlb_regfile_if #(
   parameter int unsigned TLBNUM = 16
);
   localparam int unsigned IDX_W = $clog2(TLBNUM);

   logic [5:0]       ext_int;
   logic             wen;
   logic [4:0]       addr;
   logic [2:0]       sel;
   logic [31:0]      wdata;
   logic [31:0]      rdata;
   logic             exc_valid;
   logic [4:0]       exc_code;
   logic             eret;
   logic [31:0]      pc;
   logic             in_delayslot;
   logic [31:0]      badvaddr;
   logic             tlbp;
   logic             tlbp_miss;
   logic [IDX_W-1:0] tlbp_idx;
   logic             tlbr;
   logic [31:0]      tlbr_hi;
   logic [31:0]      tlbr_lo0;
   logic [31:0]      tlbr_lo1;
   logic [31:0]      tlbr_mask;
   logic [31:0]      status;
   logic [31:0]      cause;
   logic [31:0]      epc;
   logic [31:0]      ebase;
   logic [31:0]      entry_hi;
   logic [31:0]      entry_lo0;
   logic [31:0]      entry_lo1;
   logic [31:0]      page_mask;
   logic [31:0]      index;
   logic [31:0]      tlb_context;
   logic [IDX_W-1:0] random;
   logic             int_req;

   modport master (
      output ext_int, wen, addr, sel, wdata, exc_valid, exc_code, eret, pc, in_delayslot,
             badvaddr, tlbp, tlbp_miss, tlbp_idx, tlbr, tlbr_hi, tlbr_lo0, tlbr_lo1, tlbr_mask,
      input  rdata, status, cause, epc, ebase, entry_hi, entry_lo0, entry_lo1, page_mask,
             index, tlb_context, random, int_req
   );

   modport slave (
      input  ext_int, wen, addr, sel, wdata, exc_valid, exc_code, eret, pc, in_delayslot,
             badvaddr, tlbp, tlbp_miss, tlbp_idx, tlbr, tlbr_hi, tlbr_lo0, tlbr_lo1, tlbr_mask,
      output rdata, status, cause, epc, ebase, entry_hi, entry_lo0, entry_lo1, page_mask,
             index, tlb_context, random, int_req
   );
endinterface

// File: rtl/cp0_tlb_regfile.sv
// CP0 register file with exception, timer and TLB-management registers for the
// MEM stage. Register values are exported and readable via mfc0 (rdata).
module cp0_tlb_regfile #(
   parameter int unsigned TLBNUM    = 16,
   parameter int unsigned COUNT_DIV = 2,
   parameter logic [31:0] PRID_VAL  = 32'h004c_0102,
   parameter logic [31:0] EBASE_RST = 32'h8000_0000
) (
   input logic              clk,
   input logic              rst,
   cp0_tlb_regfile_if.slave bus
);
   localparam int unsigned     IDX_W      = $clog2(TLBNUM);
   localparam int unsigned     PS_W       = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
   localparam logic [IDX_W-1:0] RAND_TOP  = IDX_W'(TLBNUM - 1);
   localparam logic [31:0]     CONFIG_VAL = 32'h0000_8000 | (32'(TLBNUM - 1) << 25);
   localparam logic [31:0]     ST_MASK    = 32'h0040_ff03;
   localparam logic [31:0]     HI_MASK    = 32'hffff_e0ff;
   localparam logic [31:0]     LO_MASK    = 32'h03ff_ffff;
   localparam logic [31:0]     PM_MASK    = 32'h01ff_e000;

   logic [31:0]      status_q, status_d;
   logic             bd_q, bd_d, ti_q, ti_d;
   logic [5:0]       ip_hw_q, ip_hw_d;
   logic [1:0]       ip_sw_q, ip_sw_d;
   logic [4:0]       exc_code_q, exc_code_d;
   logic [31:0]      epc_q, epc_d, badvaddr_q, badvaddr_d;
   logic [31:0]      count_q, count_d, compare_q, compare_d, ebase_q, ebase_d;
   logic [PS_W-1:0]  presc_q, presc_d;
   logic             index_p_q, index_p_d;
   logic [IDX_W-1:0] index_idx_q, index_idx_d;
   logic [31:0]      entry_hi_q, entry_hi_d, entry_lo0_q, entry_lo0_d;
   logic [31:0]      entry_lo1_q, entry_lo1_d, page_mask_q, page_mask_d;
   logic [8:0]       ptebase_q, ptebase_d;
   logic [18:0]      badvpn2_q, badvpn2_d;
   logic [IDX_W-1:0] wired_q, wired_d, random_q, random_d;

   logic [31:0] cause_w, index_w, context_w;
   logic        do_exc, do_mtc0, tlb_exc;

   assign do_exc  = bus.exc_valid & ~bus.eret;
   assign do_mtc0 = bus.wen & ~bus.exc_valid & ~bus.eret;
   assign tlb_exc = (bus.exc_code == 5'd1) || (bus.exc_code == 5'd2) || (bus.exc_code == 5'd3);

   // IP7 carries the timer interrupt alongside ext_int[5]
   assign cause_w   = {bd_q, ti_q, 14'b0, ip_hw_q[5] | ti_q, ip_hw_q[4:0], ip_sw_q, 1'b0,
                       exc_code_q, 2'b0};
   assign index_w   = {index_p_q, {(31 - IDX_W){1'b0}}, index_idx_q};
   assign context_w = {ptebase_q, badvpn2_q, 4'b0};

   // Next-state: mtc0 first, then exception/eret, then tlbp/tlbr override their fields
   always_comb begin
      status_d    = status_q;
      bd_d        = bd_q;
      ti_d        = ti_q;
      ip_hw_d     = bus.ext_int;
      ip_sw_d     = ip_sw_q;
      exc_code_d  = exc_code_q;
      epc_d       = epc_q;
      badvaddr_d  = badvaddr_q;
      count_d     = count_q;
      compare_d   = compare_q;
      ebase_d     = ebase_q;
      presc_d     = presc_q;
      index_p_d   = index_p_q;
      index_idx_d = index_idx_q;
      entry_hi_d  = entry_hi_q;
      entry_lo0_d = entry_lo0_q;
      entry_lo1_d = entry_lo1_q;
      page_mask_d = page_mask_q;
      ptebase_d   = ptebase_q;
      badvpn2_d   = badvpn2_q;
      wired_d     = wired_q;
      random_d    = (random_q <= wired_q) ? RAND_TOP : random_q - IDX_W'(1);

      if (presc_q == PS_W'(COUNT_DIV - 1)) begin
         presc_d = '0;
         count_d = count_q + 32'd1;
      end else begin
         presc_d = presc_q + PS_W'(1);
      end

      // Zero Compare is treated as timer disabled
      if (count_q == compare_q && compare_q != 32'd0) ti_d = 1'b1;

      if (do_mtc0) begin
         if (bus.sel == 3'd0) begin
            case (bus.addr)
               5'd0:  index_idx_d = bus.wdata[IDX_W-1:0];
               5'd2:  entry_lo0_d = bus.wdata & LO_MASK;
               5'd3:  entry_lo1_d = bus.wdata & LO_MASK;
               5'd4:  ptebase_d   = bus.wdata[31:23];
               5'd5:  page_mask_d = bus.wdata & PM_MASK;
               5'd6:  begin
                  wired_d  = bus.wdata[IDX_W-1:0];
                  random_d = RAND_TOP;
               end
               5'd9:  begin
                  count_d = bus.wdata;
                  presc_d = '0;
               end
               5'd10: entry_hi_d  = bus.wdata & HI_MASK;
               5'd11: begin
                  compare_d = bus.wdata;
                  ti_d      = 1'b0;
               end
               5'd12: status_d    = bus.wdata & ST_MASK;
               5'd13: ip_sw_d     = bus.wdata[9:8];
               5'd14: epc_d       = bus.wdata;
               default: ;
            endcase
         end else if (bus.sel == 3'd1 && bus.addr == 5'd15) begin
            ebase_d[29:12] = bus.wdata[29:12];
         end
      end

      if (bus.eret) begin
         status_d[1] = 1'b0;
      end else if (do_exc) begin
         status_d[1] = 1'b1;
         exc_code_d  = bus.exc_code;
         // Nested exceptions keep the outer EPC/BD
         if (!status_q[1]) begin
            epc_d = bus.in_delayslot ? bus.pc - 32'd4 : bus.pc;
            bd_d  = bus.in_delayslot;
         end
         if (bus.exc_code >= 5'd1 && bus.exc_code <= 5'd5) badvaddr_d = bus.badvaddr;
         if (tlb_exc) begin
            entry_hi_d[31:13] = bus.badvaddr[31:13];
            badvpn2_d         = bus.badvaddr[31:13];
         end
      end

      if (bus.tlbp) begin
         index_p_d = bus.tlbp_miss;
         if (!bus.tlbp_miss) index_idx_d = bus.tlbp_idx;
      end

      if (bus.tlbr) begin
         entry_hi_d  = bus.tlbr_hi & HI_MASK;
         entry_lo0_d = bus.tlbr_lo0 & LO_MASK;
         entry_lo1_d = bus.tlbr_lo1 & LO_MASK;
         page_mask_d = bus.tlbr_mask & PM_MASK;
      end
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         status_q    <= 32'h0040_0000;
         bd_q        <= 1'b0;
         ti_q        <= 1'b0;
         ip_hw_q     <= '0;
         ip_sw_q     <= '0;
         exc_code_q  <= '0;
         epc_q       <= '0;
         badvaddr_q  <= '0;
         count_q     <= '0;
         compare_q   <= '0;
         ebase_q     <= EBASE_RST;
         presc_q     <= '0;
         index_p_q   <= 1'b0;
         index_idx_q <= '0;
         entry_hi_q  <= '0;
         entry_lo0_q <= '0;
         entry_lo1_q <= '0;
         page_mask_q <= '0;
         ptebase_q   <= '0;
         badvpn2_q   <= '0;
         wired_q     <= '0;
         random_q    <= RAND_TOP;
      end else begin
         status_q    <= status_d;
         bd_q        <= bd_d;
         ti_q        <= ti_d;
         ip_hw_q     <= ip_hw_d;
         ip_sw_q     <= ip_sw_d;
         exc_code_q  <= exc_code_d;
         epc_q       <= epc_d;
         badvaddr_q  <= badvaddr_d;
         count_q     <= count_d;
         compare_q   <= compare_d;
         ebase_q     <= ebase_d;
         presc_q     <= presc_d;
         index_p_q   <= index_p_d;
         index_idx_q <= index_idx_d;
         entry_hi_q  <= entry_hi_d;
         entry_lo0_q <= entry_lo0_d;
         entry_lo1_q <= entry_lo1_d;
         page_mask_q <= page_mask_d;
         ptebase_q   <= ptebase_d;
         badvpn2_q   <= badvpn2_d;
         wired_q     <= wired_d;
         random_q    <= random_d;
      end
   end

   // mfc0 read decode from registered state only
   always_comb begin
      bus.rdata = 32'd0;
      if (bus.sel == 3'd0) begin
         case (bus.addr)
            5'd0:  bus.rdata = index_w;
            5'd1:  bus.rdata = 32'(random_q);
            5'd2:  bus.rdata = entry_lo0_q;
            5'd3:  bus.rdata = entry_lo1_q;
            5'd4:  bus.rdata = context_w;
            5'd5:  bus.rdata = page_mask_q;
            5'd6:  bus.rdata = 32'(wired_q);
            5'd8:  bus.rdata = badvaddr_q;
            5'd9:  bus.rdata = count_q;
            5'd10: bus.rdata = entry_hi_q;
            5'd11: bus.rdata = compare_q;
            5'd12: bus.rdata = status_q;
            5'd13: bus.rdata = cause_w;
            5'd14: bus.rdata = epc_q;
            5'd15: bus.rdata = PRID_VAL;
            5'd16: bus.rdata = CONFIG_VAL;
            default: ;
         endcase
      end else if (bus.sel == 3'd1 && bus.addr == 5'd15) begin
         bus.rdata = ebase_q;
      end
   end

   assign bus.status      = status_q;
   assign bus.cause       = cause_w;
   assign bus.epc         = epc_q;
   assign bus.ebase       = ebase_q;
   assign bus.entry_hi    = entry_hi_q;
   assign bus.entry_lo0   = entry_lo0_q;
   assign bus.entry_lo1   = entry_lo1_q;
   assign bus.page_mask   = page_mask_q;
   assign bus.index       = index_w;
   assign bus.tlb_context = context_w;
   assign bus.random      = random_q;
   assign bus.int_req     = status_q[0] & ~status_q[1] & |(cause_w[15:8] & status_q[15:8]);
endmodule

// File: tb/tb_cp0_tlb_regfile.sv
// Directed bench for cp0_tlb_regfile with hand-computed expected values.
module tb_cp0_tlb_regfile;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;

   cp0_tlb_regfile_if #(.TLBNUM(16)) bus ();

   cp0_tlb_regfile #(
      .TLBNUM   (16),
      .COUNT_DIV(2),
      .PRID_VAL (32'h004c_0102),
      .EBASE_RST(32'h8000_0000)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rd_reg(input logic [4:0] a, input logic [2:0] s, output logic [31:0] d);
      bus.addr = a;
      bus.sel  = s;
      #1;
      d = bus.rdata;
   endtask

   task automatic mtc0(input logic [4:0] a, input logic [2:0] s, input logic [31:0] d);
      bus.wen   = 1'b1;
      bus.addr  = a;
      bus.sel   = s;
      bus.wdata = d;
      tick();
      bus.wen = 1'b0;
   endtask

   task automatic exc(input logic [4:0] code, input logic [31:0] pc, input logic ds,
                      input logic [31:0] bva);
      bus.exc_valid    = 1'b1;
      bus.exc_code     = code;
      bus.pc           = pc;
      bus.in_delayslot = ds;
      bus.badvaddr     = bva;
      tick();
      bus.exc_valid = 1'b0;
   endtask

   logic [31:0] rv;
   int          rnd_exp [5] = '{15, 14, 13, 12, 15};

   initial begin
      bus.ext_int = '0; bus.wen = 0; bus.addr = '0; bus.sel = '0; bus.wdata = '0;
      bus.exc_valid = 0; bus.exc_code = '0; bus.eret = 0; bus.pc = '0;
      bus.in_delayslot = 0; bus.badvaddr = '0; bus.tlbp = 0; bus.tlbp_miss = 0;
      bus.tlbp_idx = '0; bus.tlbr = 0; bus.tlbr_hi = '0; bus.tlbr_lo0 = '0;
      bus.tlbr_lo1 = '0; bus.tlbr_mask = '0;
      tick();
      tick();

      // Reset state and constant registers
      check("rst_status", bus.status, 32'h0040_0000);
      check("rst_ebase", bus.ebase, 32'h8000_0000);
      check("rst_cause", bus.cause, 32'h0);
      check("rst_random", 32'(bus.random), 32'd15);
      check("rst_int_req", 32'(bus.int_req), 32'd0);
      rd_reg(5'd16, 3'd0, rv); check("config", rv, 32'h1e00_8000);
      rd_reg(5'd15, 3'd0, rv); check("prid", rv, 32'h004c_0102);
      rd_reg(5'd16, 3'd1, rv); check("config_sel1", rv, 32'h0);
      rst = 1'b0;

      // Random countdown with Wired=0
      for (int i = 0; i < 6; i++) begin
         check("rand_down", 32'(bus.random), 32'(15 - i));
         tick();
      end
      repeat (9) tick();
      check("rand_zero", 32'(bus.random), 32'd0);
      tick();
      check("rand_wrap", 32'(bus.random), 32'd15);
      mtc0(5'd6, 3'd0, 32'd12);
      for (int i = 0; i < 5; i++) begin
         check("rand_wired", 32'(bus.random), 32'(rnd_exp[i]));
         tick();
      end

      // Timer: Compare=5, Count=0, TI one cycle after Count reaches Compare
      mtc0(5'd12, 3'd0, 32'h0040_8001);
      mtc0(5'd11, 3'd0, 32'd5);
      mtc0(5'd9, 3'd0, 32'd0);
      repeat (10) tick();
      check("ti_early", bus.cause, 32'h0);
      tick();
      check("ti_set", bus.cause, 32'h4000_8000);
      check("ti_int_req", 32'(bus.int_req), 32'd1);
      mtc0(5'd11, 3'd0, 32'd0);
      check("ti_clear", bus.cause, 32'h0);
      check("ti_int_clr", 32'(bus.int_req), 32'd0);

      // ext_int is registered: no bypass to int_req
      bus.ext_int = 6'h20;
      #1 check("ext_nobypass", 32'(bus.int_req), 32'd0);
      tick();
      check("ext_int_req", 32'(bus.int_req), 32'd1);
      bus.ext_int = 6'h0;
      tick();

      // TLBL exception in a delay slot, then nested exception
      exc(5'd2, 32'h8000_1004, 1'b1, 32'h1234_5678);
      check("exc_epc", bus.epc, 32'h8000_1000);
      check("exc_status", bus.status, 32'h0040_8003);
      check("exc_cause", bus.cause, 32'h8000_0008);
      check("exc_entry_hi", bus.entry_hi, 32'h1234_4000);
      check("exc_context", bus.tlb_context, 32'h0009_1a20);
      rd_reg(5'd8, 3'd0, rv); check("exc_badvaddr", rv, 32'h1234_5678);
      exc(5'd0, 32'h8000_2000, 1'b0, 32'hdead_beef);
      check("nest_epc", bus.epc, 32'h8000_1000);
      check("nest_cause", bus.cause, 32'h8000_0000);
      rd_reg(5'd8, 3'd0, rv); check("nest_badvaddr", rv, 32'h1234_5678);

      // eret beats a same-cycle exception
      bus.eret = 1'b1;
      exc(5'd4, 32'h8000_3000, 1'b0, 32'h0000_1111);
      bus.eret = 1'b0;
      check("eret_status", bus.status, 32'h0040_8001);
      check("eret_epc", bus.epc, 32'h8000_1000);
      check("eret_cause", bus.cause, 32'h8000_0000);
      rd_reg(5'd8, 3'd0, rv); check("eret_badvaddr", rv, 32'h1234_5678);

      // mtc0 EPC dropped under an exception
      bus.wen = 1'b1; bus.addr = 5'd14; bus.sel = 3'd0; bus.wdata = 32'h1111_1111;
      exc(5'd0, 32'h8000_4000, 1'b0, 32'h0);
      bus.wen = 1'b0;
      check("drop_epc", bus.epc, 32'h8000_4000);
      check("drop_cause", bus.cause, 32'h0);
      bus.eret = 1'b1; tick(); bus.eret = 1'b0;

      // tlbp miss keeps the index, hit loads it
      mtc0(5'd0, 3'd0, 32'd5);
      bus.tlbp = 1'b1; bus.tlbp_miss = 1'b1; bus.tlbp_idx = 4'd9;
      tick();
      check("tlbp_miss", bus.index, 32'h8000_0005);
      bus.tlbp_miss = 1'b0; bus.tlbp_idx = 4'd7;
      tick();
      bus.tlbp = 1'b0;
      check("tlbp_hit", bus.index, 32'h0000_0007);

      // tlbr all ones, with a competing mtc0 EntryLo0
      bus.tlbr = 1'b1; bus.tlbr_hi = '1; bus.tlbr_lo0 = '1; bus.tlbr_lo1 = '1;
      bus.tlbr_mask = '1;
      mtc0(5'd2, 3'd0, 32'h0);
      bus.tlbr = 1'b0;
      check("tlbr_lo0", bus.entry_lo0, 32'h03ff_ffff);
      check("tlbr_lo1", bus.entry_lo1, 32'h03ff_ffff);
      check("tlbr_mask", bus.page_mask, 32'h01ff_e000);
      check("tlbr_hi", bus.entry_hi, 32'hffff_e0ff);

      // Writable-field masks
      mtc0(5'd12, 3'd0, 32'hffff_ffff);
      check("status_mask", bus.status, 32'h0040_ff03);
      mtc0(5'd15, 3'd1, 32'hffff_ffff);
      rd_reg(5'd15, 3'd1, rv); check("ebase_mask", rv, 32'hbfff_f000);
      mtc0(5'd12, 3'd0, 32'h0040_0000);

      // Count wrap
      mtc0(5'd9, 3'd0, 32'hffff_ffff);
      rd_reg(5'd9, 3'd0, rv); check("count_load", rv, 32'hffff_ffff);
      tick();
      rd_reg(5'd9, 3'd0, rv); check("count_hold", rv, 32'hffff_ffff);
      tick();
      rd_reg(5'd9, 3'd0, rv); check("count_wrap", rv, 32'h0);

      // Reset overrides a pending mtc0 and tlbp
      bus.wen = 1'b1; bus.addr = 5'd14; bus.sel = 3'd0; bus.wdata = 32'h5555_5555;
      bus.tlbp = 1'b1; bus.tlbp_miss = 1'b1;
      rst = 1'b1;
      tick();
      bus.wen = 1'b0; bus.tlbp = 1'b0;
      check("rst2_epc", bus.epc, 32'h0);
      check("rst2_status", bus.status, 32'h0040_0000);
      check("rst2_ebase", bus.ebase, 32'h8000_0000);
      check("rst2_index", bus.index, 32'h0);
      check("rst2_entry_hi", bus.entry_hi, 32'h0);
      check("rst2_random", 32'(bus.random), 32'd15);
      rd_reg(5'd9, 3'd0, rv); check("rst2_count", rv, 32'h0);
      rd_reg(5'd6, 3'd0, rv); check("rst2_wired", rv, 32'h0);
      rst = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
